oser_pattgen: RTL and testbench



---
 rtl/oser_pattgen_if.sv | 13 +
 rtl/oser_pattgen.sv | 192 +++++++++++++++++++
 tb/tb_oser_pattgen.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/oser_pattgen_if.sv
// Word-load handshake between an external word source and oser_pattgen.
// The source drives data/valid; the generator drives ready as its load strobe.
interface oser_pattgen_if #(
    parameter int CH    = 2,
    parameter int RATIO = 4
) ();
    logic [CH*RATIO-1:0] data;
    logic                valid;
    logic                ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/oser_pattgen.sv
// Multi-lane LSB-first serializer / test-pattern generator with bit and word strobes.
// Define OSER_PATTGEN_PRBS_EN to build the per-lane PRBS7 source; otherwise mode 2 falls back to ALT.
module oser_pattgen #(
    parameter int CH    = 2,
    parameter int RATIO = 4,
    parameter int DIV   = 8
) (
    input  logic          clk_i,
    input  logic          nrst_i,
    input  logic [1:0]    mode_i,
    oser_pattgen_if.slave bus,
    output logic [CH-1:0] q_o,
    output logic          fclk_o,
    output logic          pclk_o,
    output logic          underrun_o
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(RATIO);
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
    localparam logic [BW-1:0] BC_MAX  = BW'(RATIO - 1);
    localparam logic [BW-1:0] BC_HALF = BW'(RATIO / 2);

    function automatic logic [RATIO-1:0] alt_word();
        logic [RATIO-1:0] w;
        for (int k = 0; k < RATIO; k++) begin
            w[k] = ((k % 2) == 0) ? 1'b1 : 1'b0;
        end
        return w;
    endfunction

`ifdef OSER_PATTGEN_PRBS_EN
    function automatic logic [6:0] prbs_step(input logic [6:0] s);
        return {s[5:0], s[6] ^ s[5]};
    endfunction

    // Word bit k is the feedback bit produced by step k.
    function automatic logic [RATIO-1:0] prbs_word(input logic [6:0] s);
        logic [RATIO-1:0] w;
        logic [6:0]       st;
        st = s;
        for (int k = 0; k < RATIO; k++) begin
            st   = prbs_step(st);
            w[k] = st[0];
        end
        return w;
    endfunction

    function automatic logic [6:0] prbs_adv(input logic [6:0] s);
        logic [6:0] st;
        st = s;
        for (int k = 0; k < RATIO; k++) begin
            st = prbs_step(st);
        end
        return st;
    endfunction

    logic [CH-1:0][6:0] lfsr_r;
`endif

    logic [PW-1:0]            pre_r;
    logic [BW-1:0]            bc_r;
    logic [BW-1:0]            bc_nxt_s;
    logic                     tick_s;
    logic                     load_s;
    logic [CH-1:0][RATIO-1:0] sr_r;
    logic [CH-1:0][RATIO-1:0] cnt_r;
    logic [CH-1:0][RATIO-1:0] word_s;
    logic                     fclk_r;
    logic                     pclk_r;
    logic                     underrun_r;

    assign tick_s    = (pre_r == PRE_MAX);
    assign load_s    = tick_s && (bc_r == BC_MAX);
    assign bus.ready = load_s && (mode_i == 2'd3);

    // Next bit index, wrapping at the end of each word.
    always_comb begin
        bc_nxt_s = bc_r;
        if (!tick_s) begin
            bc_nxt_s = bc_r;
        end else if (bc_r == BC_MAX) begin
            bc_nxt_s = {BW{1'b0}};
        end else begin
            bc_nxt_s = bc_r + BW'(1);
        end
    end

    // Word each lane would load in this cycle for the current mode.
    always_comb begin
        word_s = {(CH*RATIO){1'b0}};
        for (int c = 0; c < CH; c++) begin
            case (mode_i)
                2'd0: word_s[c] = alt_word();
                2'd1: word_s[c] = cnt_r[c];
`ifdef OSER_PATTGEN_PRBS_EN
                2'd2: word_s[c] = prbs_word(lfsr_r[c]);
`else
                2'd2: word_s[c] = alt_word();
`endif
                2'd3: word_s[c] = bus.valid ? bus.data[c*RATIO +: RATIO] : {RATIO{1'b0}};
                default: word_s[c] = alt_word();
            endcase
        end
    end

    // Prescaler and bit counter.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            pre_r <= {PW{1'b0}};
            bc_r  <= BC_MAX;
        end else begin
            pre_r <= tick_s ? {PW{1'b0}} : pre_r + PW'(1);
            bc_r  <= bc_nxt_s;
        end
    end

    // Lane shift registers: load on the word boundary, shift right on other ticks.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            sr_r <= {(CH*RATIO){1'b0}};
        end else if (load_s) begin
            sr_r <= word_s;
        end else if (tick_s) begin
            for (int c = 0; c < CH; c++) begin
                sr_r[c] <= {1'b0, sr_r[c][RATIO-1:1]};
            end
        end else begin
            sr_r <= sr_r;
        end
    end

    // Per-lane counters advance only on words loaded in COUNT mode.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            for (int c = 0; c < CH; c++) begin
                cnt_r[c] <= RATIO'(c);
            end
        end else if (load_s && (mode_i == 2'd1)) begin
            for (int c = 0; c < CH; c++) begin
                cnt_r[c] <= cnt_r[c] + RATIO'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

`ifdef OSER_PATTGEN_PRBS_EN
    // Per-lane LFSRs advance RATIO steps only on words loaded in PRBS7 mode.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            for (int c = 0; c < CH; c++) begin
                lfsr_r[c] <= 7'(c + 1);
            end
        end else if (load_s && (mode_i == 2'd2)) begin
            for (int c = 0; c < CH; c++) begin
                lfsr_r[c] <= prbs_adv(lfsr_r[c]);
            end
        end else begin
            lfsr_r <= lfsr_r;
        end
    end
`endif

    // Analyzer strobes and the sticky EXT underrun flag.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            fclk_r     <= 1'b0;
            pclk_r     <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            fclk_r <= tick_s ? ~fclk_r : fclk_r;
            pclk_r <= (bc_nxt_s < BC_HALF);
            if (load_s && (mode_i == 2'd3) && !bus.valid) begin
                underrun_r <= 1'b1;
            end else begin
                underrun_r <= underrun_r;
            end
        end
    end

    // Lane outputs are taken straight from shift-register bit 0.
    always_comb begin
        q_o = {CH{1'b0}};
        for (int c = 0; c < CH; c++) begin
            q_o[c] = sr_r[c][0];
        end
    end

    assign fclk_o     = fclk_r;
    assign pclk_o     = pclk_r;
    assign underrun_o = underrun_r;
endmodule

// File: tb/tb_oser_pattgen.sv
// Scoreboard bench for oser_pattgen: per-cycle expectations from an arithmetic timing model.
// Honours OSER_PATTGEN_PRBS_EN the same way as the design.
module tb_oser_pattgen;
    localparam int CH    = 2;
    localparam int RATIO = 4;
    localparam int DIV   = 3;

    typedef struct packed {
        logic [CH-1:0] q;
        logic          fclk;
        logic          pclk;
        logic          und;
        logic          rdy;
    } exp_t;

    logic          clk = 1'b0;
    logic          nrst;
    logic [1:0]    mode;
    logic [CH-1:0] q;
    logic          fclk;
    logic          pclk;
    logic          und;

    oser_pattgen_if #(.CH(CH), .RATIO(RATIO)) bus ();

    oser_pattgen #(.CH(CH), .RATIO(RATIO), .DIV(DIV)) dut (
        .clk_i      (clk),
        .nrst_i     (nrst),
        .mode_i     (mode),
        .bus        (bus.slave),
        .q_o        (q),
        .fclk_o     (fclk),
        .pclk_o     (pclk),
        .underrun_o (und)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: edges since reset release, last loaded words, pattern sources.
    int               j;
    logic [RATIO-1:0] cur_word[CH];
    int               cnt[CH];
    bit               hist[CH][$];
    bit               und_m;

    function automatic bit is_load(input int e);
        return (e > 0) && (e % DIV == 0) && (((e / DIV) - 1) % RATIO == 0);
    endfunction

    function automatic logic [RATIO-1:0] alt_w();
        logic [RATIO-1:0] w;
        for (int k = 0; k < RATIO; k++) w[k] = ((k % 2) == 0);
        return w;
    endfunction

    task automatic model_reset();
        j     = 0;
        und_m = 1'b0;
        for (int c = 0; c < CH; c++) begin
            cur_word[c] = '0;
            cnt[c]      = c;
            hist[c].delete();
            for (int b = 6; b >= 0; b--) hist[c].push_back(bit'(((c + 1) >> b) & 1));
        end
    endtask

    // Outputs after edge j follow from tick count and bit position alone.
    function automatic exp_t expect_now();
        exp_t r;
        int   t;
        int   pos;
        r     = '0;
        r.und = und_m;
        if (j >= DIV) begin
            t   = j / DIV;
            pos = (t - 1) % RATIO;
            for (int c = 0; c < CH; c++) r.q[c] = cur_word[c][pos];
            r.fclk = (t % 2) == 1;
            r.pclk = pos < (RATIO / 2);
        end
        r.rdy = is_load(j + 1) && (mode == 2'd3);
        return r;
    endfunction

    task automatic model_edge();
        logic [RATIO-1:0] w;
        int               n;
        int               sz;
        if (is_load(j + 1)) begin
            if (mode == 2'd3 && !bus.valid) und_m = 1'b1;
            for (int c = 0; c < CH; c++) begin
                case (mode)
                    2'd1: begin
                        w = RATIO'(cnt[c] % (1 << RATIO));
                        cnt[c] = cnt[c] + 1;
                    end
                    2'd2: begin
`ifdef OSER_PATTGEN_PRBS_EN
                        for (int k = 0; k < RATIO; k++) begin
                            sz = hist[c].size();
                            n  = int'(hist[c][sz-7] ^ hist[c][sz-6]);
                            hist[c].push_back(bit'(n));
                            w[k] = n[0];
                        end
`else
                        w = alt_w();
`endif
                    end
                    2'd3: w = bus.valid ? bus.data[c*RATIO +: RATIO] : '0;
                    default: w = alt_w();
                endcase
                cur_word[c] = w;
            end
        end
        j = j + 1;
    endtask

    // One cycle of stimulus: mode_sel 0..3 fixes the mode, 4 randomizes it.
    task automatic step(input int mode_sel, input int valid_pct);
        mode      = (mode_sel < 4) ? 2'(mode_sel) : 2'($urandom_range(0, 3));
        bus.valid = ($urandom_range(0, 99) < valid_pct);
        bus.data  = (CH*RATIO)'($urandom);
        sb.push_back(expect_now());
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        sb.push_back('0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        model_reset();
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks = checks + 1;
        if (got !== want) begin
            errors = errors + 1;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
        end
    endtask

    // Monitor: compare DUT outputs with the queued expectation once per cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("q_o",        32'(q),         32'(e.q));
                chk("fclk_o",     32'(fclk),      32'(e.fclk));
                chk("pclk_o",     32'(pclk),      32'(e.pclk));
                chk("underrun_o", 32'(und),       32'(e.und));
                chk("ready_o",    32'(bus.ready), 32'(e.rdy));
            end
        end
    end

    initial begin
        nrst      = 1'b0;
        mode      = 2'd0;
        bus.valid = 1'b0;
        bus.data  = '0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        repeat (RATIO*DIV*4)  step(0, 100);
        repeat (RATIO*DIV*20) step(1, 100);
        repeat (RATIO*DIV*8)  step(2, 100);
        repeat (RATIO*DIV*6)  step(3, 100);
        repeat (400)          step(4, 100);
        repeat (RATIO*DIV*10) step(3, 60);
        repeat ($urandom_range(1, 11)) step(4, 70);
        do_reset();
        repeat (600) step(4, 75);
        repeat (5) step(4, 80);
        do_reset();
        repeat (150) step(4, 90);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
